// File: rtl/pipeline_stage_regs.sv
// IF/EX and EX/MEM pipeline registers for the 3-stage RISC-V core, with a
// one-entry fetch hold buffer, EPC capture on interrupt and a retired-instruction counter.
module pipeline_stage_regs #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush_sel,
  input  logic            interupt_sel,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_reg_wr,
  input  logic            ex_mem_read,
  output logic            fetch_hold,
  output logic [31:0]     inst_exec,
  output logic [XLEN-1:0] pc_exec,
  output logic            valid_exec,
  output logic [31:0]     inst_mem,
  output logic [XLEN-1:0] pc_mem,
  output logic [XLEN-1:0] alu_mem,
  output logic            reg_wr_mem,
  output logic            mem_read_mem,
  output logic            valid_mem,
  output logic [XLEN-1:0] epc,
  output logic            epc_valid,
  output logic [63:0]     instret
);

  logic [31:0]     inst_ex_q, inst_ex_d;
  logic [XLEN-1:0] pc_ex_q, pc_ex_d;
  logic            vld_ex_q, vld_ex_d;
  logic            buf_vld_q, buf_vld_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]     buf_inst_q, buf_inst_d;

  logic [31:0]     inst_mem_q, inst_mem_d;
  logic [XLEN-1:0] pc_mem_q, pc_mem_d;
  logic [XLEN-1:0] alu_mem_q, alu_mem_d;
  logic            reg_wr_mem_q, reg_wr_mem_d;
  logic            mem_read_mem_q, mem_read_mem_d;
  logic            vld_mem_q, vld_mem_d;

  logic [XLEN-1:0] epc_q, epc_d;
  logic            epc_vld_q, epc_vld_d;
  logic [63:0]     instret_q, instret_d;

  // IF/EX stage: kill > hold (with buffer capture) > drain buffer > take fetch
  always_comb begin
    inst_ex_d  = inst_ex_q;
    pc_ex_d    = pc_ex_q;
    vld_ex_d   = vld_ex_q;
    buf_vld_d  = buf_vld_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    if (interupt_sel || flush_sel) begin
      inst_ex_d = NOP_INST;
      vld_ex_d  = 1'b0;
      buf_vld_d = 1'b0;
    end else if (stall) begin
      // Synchronous IMEM already returned this word; park it so it is not lost.
      if (if_valid && !buf_vld_q) begin
        buf_vld_d  = 1'b1;
        buf_pc_d   = if_pc;
        buf_inst_d = if_inst;
      end
    end else if (buf_vld_q) begin
      inst_ex_d = buf_inst_q;
      pc_ex_d   = buf_pc_q;
      vld_ex_d  = 1'b1;
      buf_vld_d = 1'b0;
    end else begin
      inst_ex_d = if_valid ? if_inst : NOP_INST;
      pc_ex_d   = if_pc;
      vld_ex_d  = if_valid;
    end
  end

  // EX/MEM stage: a flush does not bubble here, so the branch itself advances
  always_comb begin
    inst_mem_d     = inst_mem_q;
    pc_mem_d       = pc_mem_q;
    alu_mem_d      = alu_mem_q;
    reg_wr_mem_d   = reg_wr_mem_q;
    mem_read_mem_d = mem_read_mem_q;
    vld_mem_d      = vld_mem_q;
    if (interupt_sel || stall) begin
      inst_mem_d     = NOP_INST;
      reg_wr_mem_d   = 1'b0;
      mem_read_mem_d = 1'b0;
      vld_mem_d      = 1'b0;
    end else begin
      inst_mem_d     = inst_ex_q;
      pc_mem_d       = pc_ex_q;
      alu_mem_d      = ex_alu_result;
      reg_wr_mem_d   = ex_reg_wr & vld_ex_q;
      mem_read_mem_d = ex_mem_read & vld_ex_q;
      vld_mem_d      = vld_ex_q;
    end
  end

  // Interrupt return point prefers the instruction in EX, then the one being fetched
  always_comb begin
    epc_d     = epc_q;
    epc_vld_d = interupt_sel;
    if (interupt_sel) begin
      if (vld_ex_q) begin
        epc_d = pc_ex_q;
      end else if (if_valid) begin
        epc_d = if_pc;
      end else begin
        epc_d = pc_ex_q;
      end
    end
    instret_d = instret_q + {63'd0, vld_mem_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_ex_q      <= NOP_INST;
      pc_ex_q        <= '0;
      vld_ex_q       <= 1'b0;
      buf_vld_q      <= 1'b0;
      buf_pc_q       <= '0;
      buf_inst_q     <= NOP_INST;
      inst_mem_q     <= NOP_INST;
      pc_mem_q       <= '0;
      alu_mem_q      <= '0;
      reg_wr_mem_q   <= 1'b0;
      mem_read_mem_q <= 1'b0;
      vld_mem_q      <= 1'b0;
      epc_q          <= '0;
      epc_vld_q      <= 1'b0;
      instret_q      <= '0;
    end else begin
      inst_ex_q      <= inst_ex_d;
      pc_ex_q        <= pc_ex_d;
      vld_ex_q       <= vld_ex_d;
      buf_vld_q      <= buf_vld_d;
      buf_pc_q       <= buf_pc_d;
      buf_inst_q     <= buf_inst_d;
      inst_mem_q     <= inst_mem_d;
      pc_mem_q       <= pc_mem_d;
      alu_mem_q      <= alu_mem_d;
      reg_wr_mem_q   <= reg_wr_mem_d;
      mem_read_mem_q <= mem_read_mem_d;
      vld_mem_q      <= vld_mem_d;
      epc_q          <= epc_d;
      epc_vld_q      <= epc_vld_d;
      instret_q      <= instret_d;
    end
  end

  assign fetch_hold   = stall | buf_vld_q;
  assign inst_exec    = inst_ex_q;
  assign pc_exec      = pc_ex_q;
  assign valid_exec   = vld_ex_q;
  assign inst_mem     = inst_mem_q;
  assign pc_mem       = pc_mem_q;
  assign alu_mem      = alu_mem_q;
  assign reg_wr_mem   = reg_wr_mem_q;
  assign mem_read_mem = mem_read_mem_q;
  assign valid_mem    = vld_mem_q;
  assign epc          = epc_q;
  assign epc_valid    = epc_vld_q;
  assign instret      = instret_q;

endmodule

// File: doc/pipeline_stage_regs.md
Name: pipeline_stage_regs

Overview:
- Holds the IF/EX and EX/MEM pipeline registers of the 3-stage RISC-V core. It produces `inst_exec` and `inst_mem`, which the hazard unit inspects.
- Consumes the hazard unit's stall and flush outputs and the interrupt select.
- Contains a 1-entry fetch hold buffer. Instruction memory is synchronous, so an instruction fetched during a stall cycle would otherwise be lost.
- Counts retired instructions.

Parameters:
- XLEN, 32, datapath/PC width.
- NOP_INST, 32'h0000_0013, bubble instruction (`addi x0,x0,0`).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  from hazard unit; hold IF/EX, insert bubble into EX/MEM.
- flush_sel  in  1  from hazard unit; kill IF/EX contents (branch taken).
- interupt_sel  in  1  interrupt accepted; kill IF/EX and EX/MEM input, capture EPC.
- if_valid  in  1  `if_inst`/`if_pc` valid this cycle.
- if_pc  in  XLEN  PC of fetched instruction.
- if_inst  in  32  fetched instruction.
- ex_alu_result  in  XLEN  EX-stage ALU result.
- ex_reg_wr  in  1  EX-stage decoded register write enable.
- ex_mem_read  in  1  EX-stage decoded load.
- fetch_hold  out  1  combinational, `stall | buf_valid`; fetch must hold PC.
- inst_exec  out  32  IF/EX instruction.
- pc_exec  out  XLEN  IF/EX PC.
- valid_exec  out  1  IF/EX valid.
- inst_mem  out  32  EX/MEM instruction.
- pc_mem  out  XLEN  EX/MEM PC.
- alu_mem  out  XLEN  EX/MEM ALU result.
- reg_wr_mem  out  1  EX/MEM register write enable (gated by valid).
- mem_read_mem  out  1  EX/MEM load (gated by valid).
- valid_mem  out  1  EX/MEM valid.
- epc  out  XLEN  exception PC, captured on interrupt.
- epc_valid  out  1  one-cycle pulse when `epc` is updated.
- instret  out  64  count of valid instructions leaving MEM.

Behaviour:
- Reset (async, immediate):
  - `inst_exec = inst_mem = NOP_INST`.
  - All PCs, `alu_mem`, `epc` and `instret` = 0.
  - All valids, `reg_wr_mem`, `mem_read_mem`, `epc_valid` and `buf_valid` = 0.
  - Reset asserted mid-operation discards buffer and pipeline contents with no partial update.
- IF/EX update, per posedge, priority `interupt_sel` > `flush_sel` > `stall` > normal:
  - interrupt or flush: `inst_exec <= NOP_INST`, `valid_exec <= 0`, `buf_valid <= 0`.
  - stall: IF/EX holds. If `if_valid && !buf_valid`, capture `if_pc`/`if_inst` into the buffer and set `buf_valid <= 1`. If the buffer is already full, `if_*` is ignored (fetch is held).
  - normal with `buf_valid`: load IF/EX from the buffer, `buf_valid <= 0`, ignore `if_*` this cycle.
  - normal without `buf_valid`: load `if_pc`, `if_inst`, `valid_exec <= if_valid`. If `!if_valid`, load `NOP_INST`.
- EX/MEM update, priority `interupt_sel` > `stall` > normal:
  - interrupt or stall: bubble. `inst_mem <= NOP_INST`; `valid_mem`, `reg_wr_mem`, `mem_read_mem <= 0`; PC and ALU result registers hold.
  - normal, including while `flush_sel` is high: load `inst_exec`, `pc_exec`, `ex_alu_result`, `valid_exec`. `reg_wr_mem <= ex_reg_wr & valid_exec`; `mem_read_mem <= ex_mem_read & valid_exec`.
  - The branch in EX therefore still advances on a flush.
- Interrupt:
  - On the `interupt_sel` posedge, `epc <=` `pc_exec` if `valid_exec`, else `if_pc` if `if_valid`, else `pc_exec`.
  - `epc_valid <= 1` for exactly that one cycle. The `valid_mem` instruction still retires.
  - `interupt_sel` held multiple cycles: `epc` is recaptured each cycle and `epc_valid` stays high.
- `instret`: increments by 1 on each posedge where `valid_mem` is 1. 64-bit, wraps from all-ones to 0.
- Latency: fetched instruction reaches `inst_exec` 1 cycle after it is presented (no stall), and `inst_mem` 1 cycle later.
- `fetch_hold` is purely combinational. No output depends combinationally on `if_*`.

Test Plan:
- Reset asserted 2 cycles, then 3 sequential fetches with `if_pc` = 0x0, 0x4, 0x8 → `inst_exec` appears at t+1 and `inst_mem` at t+2 in order; `instret` = 3 after draining.
- Load-use: `stall` = 1 for 1 cycle while `if_inst` = 32'h0020_8133 at `pc` 0x10 → IF/EX holds; `inst_mem` = NOP with `reg_wr_mem` = 0; `buf_valid` = 1 and `fetch_hold` = 1 for one cycle after `stall` drops; the 0x10 instruction enters EX next; no instruction lost or duplicated.
- Branch in EX at `pc` 0x20 with `flush_sel` = 1 → `pc_mem` = 0x20 and `valid_mem` = 1 next cycle; `inst_exec` = 32'h0000_0013 and `valid_exec` = 0.
- `stall` and `flush_sel` together → IF/EX = NOP; EX/MEM bubble; buffer cleared.
- `interupt_sel` pulse with `valid_exec` = 1 and `pc_exec` = 0x40 → `epc` = 0x40 and `epc_valid` high exactly 1 cycle; both stages bubbled next cycle.
- Async reset asserted mid-clock during a stall with `buf_valid` = 1 → all outputs return to reset values before the next posedge; first fetch after release enters normally.
- Preload `instret` near all-ones via forced retirements → wraps to 0.
